// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
//   state_t          : arbiter FSM states
//   REQ_CPU/REQ_DBG  : requester ids as driven on the owner output
//   DEFAULT_TIMEOUT  : default BUSY-cycle budget while waiting for mem_ready
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector with ownership lock.
//   req[1:0]  : request per requester (index = requester id)
//   lock[1:0] : lock per requester; only the current owner's lock matters
//   last      : current owner (previous winner)
//   valid     : a winner exists
//   winner    : selected requester id
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = 1'b0;
        winner = last;
        if (lock[last]) begin
            // Locked owner keeps the grant path; nobody else is eligible.
            valid  = req[last];
            winner = last;
        end else if (req[0] && req[1]) begin
            valid  = 1'b1;
            winner = ~last;
        end else if (req[0]) begin
            valid  = 1'b1;
            winner = REQ_CPU;
        end else if (req[1]) begin
            valid  = 1'b1;
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a cpu and a dbg requester onto a single memory port.
//   clk, reset                : clock, synchronous active-high reset
//   cpu_*/dbg_* (in)          : req, we, addr, wdata, size, lock per requester
//   cpu_*/dbg_* (out)         : ack pulse, err flag, rdata (valid with ack)
//   mem_req/we/addr/wdata/size: memory command, driven only while BUSY
//   mem_rdata, mem_ready      : memory response
//   owner, busy               : current owner (0 cpu, 1 dbg), transaction active
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         dbg_req,
    input  logic         cpu_we,
    input  logic         dbg_we,
    input  logic [W-1:0] cpu_addr,
    input  logic [W-1:0] dbg_addr,
    input  logic [W-1:0] cpu_wdata,
    input  logic [W-1:0] dbg_wdata,
    input  logic [3:0]   cpu_size,
    input  logic [3:0]   dbg_size,
    input  logic         cpu_lock,
    input  logic         dbg_lock,
    output logic         cpu_ack,
    output logic         dbg_ack,
    output logic         cpu_err,
    output logic         dbg_err,
    output logic [W-1:0] cpu_rdata,
    output logic [W-1:0] dbg_rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic [3:0]   mem_size,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         owner,
    output logic         busy
);

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    state_t       state, state_n;
    logic [3:0]   cnt;
    logic         we_r;
    logic [W-1:0] addr_r, wdata_r, rdata_r;
    logic [3:0]   size_r;
    logic         err_r;
    logic         pick_valid, pick_winner;
    logic         tmo_hit;

    rr_pick2 u_pick (
        .req    ({dbg_req, cpu_req}),
        .lock   ({dbg_lock, cpu_lock}),
        .last   (owner),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign tmo_hit = (cnt + 4'd1) == TMO;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_valid) state_n = BUSY;
            BUSY:    if (mem_ready || tmo_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= REQ_DBG;
            cnt     <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            size_r  <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (pick_valid) begin
                    owner <= pick_winner;
                    cnt   <= '0;
                    if (pick_winner == REQ_DBG) begin
                        we_r    <= dbg_we;
                        addr_r  <= dbg_addr;
                        wdata_r <= dbg_wdata;
                        size_r  <= dbg_size;
                    end else begin
                        we_r    <= cpu_we;
                        addr_r  <= cpu_addr;
                        wdata_r <= cpu_wdata;
                        size_r  <= cpu_size;
                    end
                end
                BUSY: begin
                    // mem_ready is tested first so it wins on the last timeout cycle.
                    if (mem_ready) begin
                        rdata_r <= we_r ? '0 : mem_rdata;
                        err_r   <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (tmo_hit) begin
                            rdata_r <= '0;
                            err_r   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == BUSY) || (state == DONE);
    assign mem_req   = (state == BUSY);
    assign mem_we    = mem_req ? we_r    : 1'b0;
    assign mem_addr  = mem_req ? addr_r  : '0;
    assign mem_wdata = mem_req ? wdata_r : '0;
    assign mem_size  = mem_req ? size_r  : '0;

    assign cpu_ack   = (state == DONE) && (owner == REQ_CPU);
    assign dbg_ack   = (state == DONE) && (owner == REQ_DBG);
    assign cpu_err   = cpu_ack ? err_r   : 1'b0;
    assign dbg_err   = dbg_ack ? err_r   : 1'b0;
    assign cpu_rdata = cpu_ack ? rdata_r : '0;
    assign dbg_rdata = dbg_ack ? rdata_r : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, dbg_req, cpu_we, dbg_we, cpu_lock, dbg_lock;
    logic [31:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
    logic [3:0]  cpu_size, dbg_size;
    logic        cpu_ack, dbg_ack, cpu_err, dbg_err;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        owner, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(15), .W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .dbg_req(dbg_req),
        .cpu_we(cpu_we), .dbg_we(dbg_we),
        .cpu_addr(cpu_addr), .dbg_addr(dbg_addr),
        .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
        .cpu_size(cpu_size), .dbg_size(dbg_size),
        .cpu_lock(cpu_lock), .dbg_lock(dbg_lock),
        .cpu_ack(cpu_ack), .dbg_ack(dbg_ack),
        .cpu_err(cpu_err), .dbg_err(dbg_err),
        .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction starting in IDLE with mem_ready in the first BUSY cycle.
    task automatic run_txn(input string tag, input logic exp_owner, input logic [31:0] exp_addr,
                           input logic [31:0] rd, input logic [31:0] exp_rdata);
        tick();
        check({tag, ".owner"}, owner, exp_owner);
        check({tag, ".mem_req"}, mem_req, 1'b1);
        check({tag, ".mem_addr"}, mem_addr, exp_addr);
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        check({tag, ".ack"}, {cpu_ack, dbg_ack}, exp_owner ? 2'b01 : 2'b10);
        check({tag, ".rdata"}, exp_owner ? dbg_rdata : cpu_rdata, exp_rdata);
        check({tag, ".err"}, cpu_err | dbg_err, 1'b0);
        check({tag, ".mem_req_done"}, mem_req, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0; cpu_lock = 0; dbg_lock = 0;
        cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
        cpu_size = '0; dbg_size = '0; mem_rdata = '0; mem_ready = 0;
        #1;
        do_reset();

        // Reset state
        check("rst.busy", busy, 1'b0);
        check("rst.owner", owner, 1'b1);
        check("rst.mem_req", mem_req, 1'b0);
        check("rst.acks", {cpu_ack, dbg_ack, cpu_err, dbg_err}, 4'b0000);
        check("rst.mem_addr", mem_addr, 32'h0);

        // mem_ready outside BUSY is ignored
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        check("idle_ready.busy", busy, 1'b0);
        check("idle_ready.ack", {cpu_ack, dbg_ack}, 2'b00);
        mem_ready = 1'b0;

        // Basic cpu read, latency and registered copy
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_size = 4'd2;
        tick();
        check("rd.busy", busy, 1'b1);
        check("rd.owner", owner, 1'b0);
        check("rd.mem_req", mem_req, 1'b1);
        check("rd.mem_size", mem_size, 4'd2);
        cpu_addr = 32'h200; cpu_size = 4'd7;
        #1;
        check("rd.mem_addr_held", mem_addr, 32'h100);
        check("rd.mem_size_held", mem_size, 4'd2);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 0; cpu_req = 0;
        check("rd.cpu_ack", cpu_ack, 1'b1);
        check("rd.cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rd.cpu_err", cpu_err, 1'b0);
        check("rd.dbg_ack", dbg_ack, 1'b0);
        check("rd.dbg_rdata", dbg_rdata, 32'h0);
        check("rd.busy_done", busy, 1'b1);
        tick();
        check("rd.idle_ack", cpu_ack, 1'b0);
        check("rd.idle_busy", busy, 1'b0);

        // Contention: cpu first after reset, then dbg
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h400;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h500; dbg_wdata = 32'h55;
        run_txn("rr0", 1'b0, 32'h400, 32'hA5A5_0001, 32'hA5A5_0001);
        tick();
        check("rr1.owner", owner, 1'b1);
        check("rr1.mem_we", mem_we, 1'b1);
        check("rr1.mem_wdata", mem_wdata, 32'h55);
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ready = 0;
        check("rr1.dbg_ack", {cpu_ack, dbg_ack}, 2'b01);
        check("rr1.dbg_rdata_wr", dbg_rdata, 32'h0);
        tick();

        // dbg lock holds ownership for 3 writes while cpu waits
        dbg_lock = 1;
        run_txn("lock0", 1'b1, 32'h500, 32'h1, 32'h0);
        dbg_addr = 32'h504;
        run_txn("lock1", 1'b1, 32'h504, 32'h2, 32'h0);
        dbg_addr = 32'h508;
        run_txn("lock2", 1'b1, 32'h508, 32'h3, 32'h0);
        dbg_lock = 0;
        run_txn("unlock", 1'b0, 32'h400, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // Owner lock with owner req low blocks the other requester
        cpu_req = 0; cpu_lock = 1; dbg_req = 1;
        tick();
        check("lockidle.busy", busy, 1'b0);
        check("lockidle.owner", owner, 1'b0);
        cpu_lock = 0;
        tick();
        check("lockrel.owner", owner, 1'b1);
        check("lockrel.mem_req", mem_req, 1'b1);
        mem_ready = 1; mem_rdata = 32'h7;
        tick();
        mem_ready = 0; dbg_req = 0;
        check("lockrel.dbg_ack", dbg_ack, 1'b1);
        tick();

        // Timeout: 15 BUSY cycles without mem_ready
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300; mem_rdata = 32'hCAFE_CAFE;
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("tmo.busy15", mem_req, 1'b1);
        check("tmo.noack15", cpu_ack, 1'b0);
        tick();
        check("tmo.cpu_ack", cpu_ack, 1'b1);
        check("tmo.cpu_err", cpu_err, 1'b1);
        check("tmo.cpu_rdata", cpu_rdata, 32'h0);
        check("tmo.mem_req", mem_req, 1'b0);
        cpu_req = 0;
        tick();
        check("tmo.idle_ack", cpu_ack, 1'b0);

        // mem_ready on the last timeout cycle wins
        cpu_req = 1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        mem_ready = 1; mem_rdata = 32'h1234;
        tick();
        mem_ready = 0; cpu_req = 0;
        check("tmo_ready.ack", cpu_ack, 1'b1);
        check("tmo_ready.err", cpu_err, 1'b0);
        check("tmo_ready.rdata", cpu_rdata, 32'h1234);
        tick();

        // Reset during the second BUSY cycle abandons the transaction
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h600;
        tick();
        tick();
        check("rstmid.busy2", mem_req, 1'b1);
        reset = 1; dbg_req = 0;
        tick();
        reset = 0;
        check("rstmid.mem_req", mem_req, 1'b0);
        check("rstmid.busy", busy, 1'b0);
        check("rstmid.owner", owner, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rstmid.noack", {cpu_ack, dbg_ack}, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max BUSY cycles waiting for mem_ready (range 1..15).
REQ-002 SHALL have parameter W, default 32: address/data width.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports cpu_req, dbg_req  in  1 each  transaction request, held until the matching ack.
REQ-006 SHALL have ports cpu_we, dbg_we  in  1 each  1 = write, 0 = read.
REQ-007 SHALL have ports cpu_addr, dbg_addr, cpu_wdata, dbg_wdata  in  W each  address and write data.
REQ-008 SHALL have ports cpu_size, dbg_size  in  4 each  access size code, passed through unchanged.
REQ-009 SHALL have ports cpu_lock, dbg_lock  in  1 each  keep ownership across transactions.
REQ-010 SHALL have ports cpu_ack, dbg_ack, cpu_err, dbg_err  out  1 each  completion pulse and fault flag.
REQ-011 SHALL have ports cpu_rdata, dbg_rdata  out  W each  read data, valid while ack is high.
REQ-012 SHALL have ports mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  W; mem_size  out  4.
REQ-013 SHALL have ports mem_rdata  in  W and mem_ready  in  1  (memory completes in the cycle mem_ready=1).
REQ-014 SHALL have ports owner  out  1  (0 = cpu, 1 = dbg) and busy  out  1.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; busy=1 in BUSY and DONE.
REQ-016 In IDLE with at least one eligible req, SHALL select a winner, register its we/addr/wdata/size, set owner, and enter BUSY.
REQ-017 Both req high: winner SHALL be the requester that is not owner (round-robin); a single req SHALL win immediately.
REQ-018 lock: if owner's lock=1 in IDLE, only owner SHALL be eligible, even while owner's req=0.
REQ-019 SHALL drive mem_req=1 and mem_* from the registered copy only in BUSY; mem_req=0 otherwise.
REQ-020 BUSY with mem_ready=1: SHALL capture mem_rdata (0 for writes), clear err, and enter DONE.
REQ-021 SHALL use a 4-bit timeout counter: cleared on entering BUSY, +1 per BUSY cycle without mem_ready; on reaching TIMEOUT, SHALL enter DONE with err=1, rdata=0.
REQ-022 mem_ready together with the last timeout cycle: ready SHALL win, err=0.
REQ-023 DONE: SHALL assert owner's ack for exactly one cycle with rdata/err valid; the other requester's ack/err/rdata SHALL be 0.
REQ-024 Requester SHALL drop or renew req at the edge ending DONE; arbiter SHALL NOT sample req in DONE.
REQ-025 Latency: req high at edge N in IDLE, mem_ready in first BUSY cycle -> ack in cycle N+2; minimum 3 cycles per transaction.
REQ-026 Request field changes while BUSY SHALL have no effect on mem_* (registered copy).
REQ-027 mem_ready outside BUSY SHALL be ignored.

Reset
REQ-028 On reset: state=IDLE, owner=1 (cpu wins the first contention), counter=0, all acks/errs/mem_req/mem_we=0, rdata/mem_addr/mem_wdata=0, mem_size=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no ack in any later cycle.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/BUSY/DONE), requester-id constants (REQ_CPU=0, REQ_DBG=1) and the default TIMEOUT.
REQ-031 The two-way round-robin/lock selection SHALL be a sub-module rr_pick2 (inputs req[1:0], lock[1:0], last; outputs valid, winner).

Verification
REQ-032 After reset, cpu_req=1 read addr=0x100, mem_ready in first BUSY cycle with rdata=0xDEADBEEF -> cpu_ack=1 with cpu_rdata=0xDEADBEEF two cycles later, err=0.
REQ-033 cpu_req and dbg_req high together across 2 transactions -> grants cpu then dbg; owner sequence 0,1.
REQ-034 dbg_lock=1, dbg issues 3 writes while cpu_req is held -> cpu is not granted until dbg_lock=0, then cpu is granted next.
REQ-035 mem_ready held low -> after 15 BUSY cycles, ack=1 with err=1 and rdata=0; mem_req drops in the DONE cycle.
REQ-036 reset asserted in the second BUSY cycle -> next cycle IDLE, mem_req=0, and no ack ever appears for that transaction.
